// File: rtl/color_snn_pkg.sv
// Shared constants, state type and rate saturation for the colour spike encoder.
package color_snn_pkg;

  localparam int          CH_W      = 16;
  localparam int          RATE_W    = 8;
  localparam int          NUM_CH    = 3;
  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } enc_state_t;

  function automatic logic [RATE_W-1:0] sat_rate(
    input logic [CH_W-1:0] ch,
    input int              shift
  );
    logic [CH_W-1:0] s;
    s = ch >> shift;
    return (s > CH_W'(255)) ? 8'hFF : s[RATE_W-1:0];
  endfunction

endpackage

// File: rtl/color_spike_encoder_lfsr32.sv
// 32-bit Galois LFSR that steps only when adv is high; reset restores the seed.
module lfsr32
  import color_snn_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] state
);

  // An all-zero state would lock up, so it is replaced by 1.
  localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else if (adv) begin
      state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
    end
  end

endmodule

// File: rtl/color_spike_encoder.sv
// Rate-codes one RGB sample into WINDOW spike timesteps for the SNN input layer.
// Define SPIKE_COUNT_EN to add per-channel spike totals on spike_cnt.
module color_spike_encoder
  import color_snn_pkg::*;
#(
  parameter int          WINDOW     = 64,
  parameter int          GAIN_SHIFT = 8,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468,
  localparam int         IW         = $clog2(WINDOW),
  localparam int         CW         = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   red,
  input  logic [CH_W-1:0]   green,
  input  logic [CH_W-1:0]   blue,
  output logic [NUM_CH-1:0] spike,
  output logic              spike_valid,
  input  logic              spike_ready,
  output logic [IW-1:0]     step_idx,
`ifdef SPIKE_COUNT_EN
  output logic [3*CW-1:0]   spike_cnt,
`endif
  output logic              window_done
);

  enc_state_t        r_state;
  enc_state_t        w_next;
  logic [CH_W-1:0]   r_ch   [NUM_CH];
  logic [RATE_W-1:0] r_rate [NUM_CH];
  logic [IW-1:0]     r_idx;
  logic [LFSR_W-1:0] w_lfsr;
  logic [NUM_CH-1:0] w_spike;
  logic              w_adv;
  logic              w_last;

  assign w_adv  = (r_state == RUN) && spike_ready;
  assign w_last = (r_idx == IW'(WINDOW - 1));

  lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (w_adv),
    .state (w_lfsr)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = LOAD;
      LOAD: w_next = RUN;
      RUN:  if (spike_ready && w_last) w_next = DONE;
      DONE: w_next = IDLE;
    endcase
  end

  // Channel c draws its random byte from lfsr[8c+7:8c]; rate 255 forces a spike.
  always_comb begin
    w_spike = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_spike[c] = (r_state == RUN) &&
                   ((r_rate[c] == 8'hFF) ||
                    (w_lfsr[8*c +: 8] < r_rate[c]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_ch[c]   <= '0;
        r_rate[c] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_ch[0] <= red;
        r_ch[1] <= green;
        r_ch[2] <= blue;
      end
      if (r_state == LOAD) begin
        r_idx <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          r_rate[c] <= sat_rate(r_ch[c], GAIN_SHIFT);
        end
      end
      if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [CW-1:0] r_cnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else if (r_state == LOAD) begin
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else if (w_adv) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= r_cnt[c] + CW'(w_spike[c]);
      end
    end
  end

  assign spike_cnt = {r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

  assign in_ready    = (r_state == IDLE) && rst;
  assign spike       = w_spike;
  assign spike_valid = (r_state == RUN);
  assign step_idx    = r_idx;
  assign window_done = (r_state == DONE);

endmodule

// File: tb/tb_color_spike_encoder.sv
// Directed bench for color_spike_encoder with a reference LFSR model.
module tb_color_spike_encoder;

  localparam int          WINDOW = 64;
  localparam int          IW     = 6;
  localparam int          CW     = 7;
  localparam logic [31:0] SEED   = 32'hACE12468;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          spike_ready = 1'b1;
  logic [15:0]   red = '0;
  logic [15:0]   green = '0;
  logic [15:0]   blue = '0;
  logic          in_ready;
  logic [2:0]    spike;
  logic          spike_valid;
  logic [IW-1:0] step_idx;
  logic          window_done;
`ifdef SPIKE_COUNT_EN
  logic [3*CW-1:0] spike_cnt;
`endif

  color_spike_encoder #(
    .WINDOW     (WINDOW),
    .GAIN_SHIFT (8),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .spike       (spike),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .step_idx    (step_idx),
`ifdef SPIKE_COUNT_EN
    .spike_cnt   (spike_cnt),
`endif
    .window_done (window_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_lfsr;
  int          tot [3];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  // GAIN_SHIFT=8 on a 16-bit count never exceeds 255, so rate is the top byte.
  function automatic logic [2:0] exp_spike(input logic [15:0] r, g, b,
                                           input logic [31:0] s);
    logic [7:0] rt [3];
    logic [2:0] e;
    rt[0] = r[15:8];
    rt[1] = g[15:8];
    rt[2] = b[15:8];
    for (int c = 0; c < 3; c++)
      e[c] = (rt[c] == 8'hFF) || (s[8*c +: 8] < rt[c]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] r, g, b, input bit keep);
    int n;
    red = r;
    green = g;
    blue = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 1);
    tick();
    if (!keep) in_valid = 1'b0;
    check("load_valid", 32'(spike_valid), 0);
    tick();
  endtask

  task automatic run_window(input logic [15:0] r, g, b,
                            input int stall_at, input int abort_at,
                            input bit chk_busy);
    int         c [3];
    logic [2:0] e;
    c = '{0, 0, 0};
    for (int k = 0; k < WINDOW; k++) begin
      if (k == abort_at) begin
        rst = 1'b0;
        tick();
        check("abort_valid", 32'(spike_valid), 0);
        check("abort_done", 32'(window_done), 0);
        check("abort_idx", 32'(step_idx), 0);
        check("abort_spike", 32'(spike), 0);
        rst = 1'b1;
        m_lfsr = SEED;
        tick();
        check("abort_idle", 32'(in_ready), 1);
        check("abort_nodone", 32'(window_done), 0);
        return;
      end
      e = exp_spike(r, g, b, m_lfsr);
      check("step_valid", 32'(spike_valid), 1);
      check("step_idx", 32'(step_idx), 32'(k));
      check("spike", 32'(spike), 32'(e));
      if (chk_busy) check("busy_ready", 32'(in_ready), 0);
      if (k == stall_at) begin
        spike_ready = 1'b0;
        repeat (5) begin
          tick();
          check("stall_idx", 32'(step_idx), 32'(k));
          check("stall_spike", 32'(spike), 32'(e));
          check("stall_valid", 32'(spike_valid), 1);
        end
        spike_ready = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        c[i] += int'(e[i]);
        tot[i] += int'(e[i]);
      end
      m_lfsr = lfsr_next(m_lfsr);
      tick();
    end
    check("done_pulse", 32'(window_done), 1);
    check("done_valid", 32'(spike_valid), 0);
    check("done_ready", 32'(in_ready), 0);
`ifdef SPIKE_COUNT_EN
    check("spike_cnt", 32'(spike_cnt),
          32'({CW'(c[2]), CW'(c[1]), CW'(c[0])}));
`endif
  endtask

  initial begin
    tot = '{0, 0, 0};
    rst = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(spike_valid), 0);
    check("rst_spike", 32'(spike), 0);
    check("rst_idx", 32'(step_idx), 0);
    check("rst_done", 32'(window_done), 0);
    check("rst_ready", 32'(in_ready), 0);
`ifdef SPIKE_COUNT_EN
    check("rst_cnt", 32'(spike_cnt), 0);
`endif
    rst = 1'b1;
    m_lfsr = SEED;
    tick();
    check("idle_ready", 32'(in_ready), 1);

    // Zero intensity never spikes; done pulse is a single cycle.
    send(16'h0000, 16'h0000, 16'h0000, 1'b0);
    run_window(16'h0000, 16'h0000, 16'h0000, -1, -1, 1'b0);
    tick();
    check("t1_done_off", 32'(window_done), 0);
    check("t1_idle", 32'(in_ready), 1);

    // Saturated red/blue spike on every step, green never.
    tot = '{0, 0, 0};
    send(16'hFFFF, 16'h0000, 16'hFF00, 1'b0);
    run_window(16'hFFFF, 16'h0000, 16'hFF00, -1, -1, 1'b0);
    check("t2_red", 32'(tot[0]), 64);
    check("t2_green", 32'(tot[1]), 0);
    check("t2_blue", 32'(tot[2]), 64);
    tick();

    // Rate 64 over four windows with the LFSR carrying over.
    tot = '{0, 0, 0};
    repeat (4) begin
      send(16'h4000, 16'h0000, 16'h0000, 1'b0);
      run_window(16'h4000, 16'h0000, 16'h0000, -1, -1, 1'b0);
      tick();
    end
    check("t3_range", 32'(tot[0] >= 40 && tot[0] <= 88), 1);

    // Five-cycle stall at step 10.
    send(16'h8000, 16'h4000, 16'hC000, 1'b0);
    run_window(16'h8000, 16'h4000, 16'hC000, 10, -1, 1'b0);
    tick();

    // Reset mid-window, then the seed sequence restarts.
    send(16'h8000, 16'h8000, 16'h8000, 1'b0);
    run_window(16'h8000, 16'h8000, 16'h8000, -1, 20, 1'b0);
    send(16'h8000, 16'h8000, 16'h8000, 1'b0);
    run_window(16'h8000, 16'h8000, 16'h8000, -1, -1, 1'b0);
    tick();

    // Back-to-back samples with in_valid held high.
    send(16'h8000, 16'h2000, 16'h0000, 1'b1);
    red = 16'h0000;
    green = 16'hFFFF;
    blue = 16'hFFFF;
    run_window(16'h8000, 16'h2000, 16'h0000, -1, -1, 1'b1);
    tick();
    check("t6_idle_ready", 32'(in_ready), 1);
    tick();
    check("t6_load_ready", 32'(in_ready), 0);
    check("t6_load_valid", 32'(spike_valid), 0);
    in_valid = 1'b0;
    tick();
    run_window(16'h0000, 16'hFFFF, 16'hFFFF, -1, -1, 1'b0);
    tick();
    check("t6_end_idle", 32'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
